riscv_io_responder: RTL and testbench

RISCV_IO_RESPONDER -- requirements
Module: riscv_io_responder

---
 rtl/riscv_io_responder.sv | 130 +++++++++++++
 tb/tb_riscv_io_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_io_responder.sv
// Memory-mapped board I/O for a small RISC-V core: switches, debounced keys with
// sticky press events, LEDs, and a run/single-step pipeline enable.
`timescale 1ns/1ps
module riscv_io_responder #(
  parameter int unsigned          XLEN            = 32,
  parameter logic [XLEN-1:0]      BASE_ADDR       = 'h1000_0100,
  parameter int unsigned          DEBOUNCE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            we,
  input  logic            re,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            hit,
  input  logic [9:0]      switch,
  input  logic [1:0]      key,
  output logic [9:0]      led,
  output logic            step
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [4:0] OFF_SW   = 5'h00;
  localparam logic [4:0] OFF_KEY  = 5'h04;
  localparam logic [4:0] OFF_EDGE = 5'h08;
  localparam logic [4:0] OFF_LED  = 5'h0C;
  localparam logic [4:0] OFF_CTRL = 5'h10;

  typedef enum logic {ST_RUN, ST_STEP} state_t;

  state_t              state, state_next;
  logic                step_next;
  logic [9:0]          sw_s1, sw_s2;
  logic [1:0]          key_s1, key_s2;
  logic [1:0]          deb, deb_prev;
  logic [1:0][CW-1:0]  cnt;
  logic [1:0]          press;
  logic [1:0]          edge_q;
  logic [9:0]          led_q;
  logic [4:0]          off;
  logic                wr, rd;
  logic [XLEN-1:0]     rd_val;
  logic                unused_wdata;

  assign hit          = (addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
  assign off          = addr[4:0];
  assign wr           = we && hit;
  assign rd           = re && hit;
  assign led          = led_q;
  assign unused_wdata = ^wdata[XLEN-1:10];

  // Press event fires the cycle after the debounced state rises, so step lands
  // one registered stage after the debounced change.
  assign press = deb & ~deb_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      key_s1   <= '1;
      key_s2   <= '1;
      deb      <= '0;
      deb_prev <= '0;
      cnt      <= '0;
    end else begin
      sw_s1    <= switch;
      sw_s2    <= sw_s1;
      key_s1   <= key;
      key_s2   <= key_s1;
      deb_prev <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (~key_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_SW:   rd_val = XLEN'(sw_s2);
      OFF_KEY:  rd_val = XLEN'(deb);
      OFF_EDGE: rd_val = XLEN'(edge_q);
      OFF_LED:  rd_val = XLEN'(led_q);
      OFF_CTRL: rd_val = XLEN'(state == ST_RUN);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      led_q  <= '0;
      edge_q <= '0;
    end else begin
      rdata  <= rd ? rd_val : '0;
      rvalid <= rd;
      if (wr && off == OFF_LED) led_q <= wdata[9:0];
      // Set wins over a same-cycle W1C clear.
      edge_q <= (edge_q & ~((wr && off == OFF_EDGE) ? wdata[1:0] : 2'b00)) | press;
    end
  end

  always_comb begin
    state_next = state;
    if (wr && off == OFF_CTRL) state_next = wdata[0] ? ST_RUN : ST_STEP;
    step_next = (state_next == ST_RUN) || press[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      step  <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

endmodule

// File: tb/tb_riscv_io_responder.sv
// Scoreboard bench for riscv_io_responder: loads push expected data, a negedge
// monitor pops and compares whenever rvalid is seen.
`timescale 1ns/1ps
module tb_riscv_io_responder;

  localparam logic [31:0] BASE = 32'h1000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        hit;
  logic [9:0]  sw    = '0;
  logic [1:0]  key   = 2'b11;
  logic [9:0]  led;
  logic        step;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  riscv_io_responder #(
    .XLEN(32),
    .BASE_ADDR(32'h1000_0100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .hit(hit), .switch(sw), .key(key),
    .led(led), .step(step)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else check(nm_q.pop_front(), rdata, exp_q.pop_front());
    end else if (!reset) begin
      check("idle_rdata", {rdata[31:1], rdata[0] | rvalid}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic load(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    tick(1);
    re = 1'b0;
  endtask

  task automatic count_steps(input int n, output int pulses, output int last_idx);
    pulses = 0;
    last_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (step) begin
        pulses++;
        last_idx = i;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, idx;

    repeat (3) begin
      @(negedge clock);
      check("reset_led", 32'(led), 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_step", 32'(step), 32'd0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    tick(1);
    check("step_after_reset", 32'(step), 32'd1);

    sw = 10'h155;
    tick(3);
    load("sw_read", BASE + 32'h00, 32'h155);

    store(BASE + 32'h10, 32'h0);
    check("step_stopped", 32'(step), 32'd0);
    key = 2'b10;
    count_steps(20, pulses, idx);
    check("step_pulses_press", 32'(pulses), 32'd1);
    check("step_pulse_cycle", 32'(idx), 32'd7);
    load("key_pressed", BASE + 32'h04, 32'h1);
    load("edge_set", BASE + 32'h08, 32'h1);
    load("edge_read_no_clear", BASE + 32'h08, 32'h1);
    store(BASE + 32'h08, 32'h1);
    load("edge_w1c", BASE + 32'h08, 32'h0);

    key = 2'b11;
    count_steps(12, pulses, idx);
    check("step_pulses_release", 32'(pulses), 32'd0);
    load("key_released", BASE + 32'h04, 32'h0);
    load("edge_no_release_evt", BASE + 32'h08, 32'h0);

    key = 2'b01;
    count_steps(12, pulses, idx);
    check("step_pulses_key1", 32'(pulses), 32'd0);
    load("edge_key1", BASE + 32'h08, 32'h2);
    load("key_key1", BASE + 32'h04, 32'h2);
    store(BASE + 32'h08, 32'h2);
    key = 2'b11;
    tick(10);
    load("edge_key1_cleared", BASE + 32'h08, 32'h0);

    for (int i = 0; i < 10; i++) begin
      key = {1'b1, ((i / 2) % 2) == 1};
      count_steps(1, pulses, idx);
      check("step_bounce", 32'(pulses), 32'd0);
    end
    key = 2'b11;
    count_steps(10, pulses, idx);
    check("step_bounce_tail", 32'(pulses), 32'd0);
    load("key_bounce", BASE + 32'h04, 32'h0);
    load("edge_bounce", BASE + 32'h08, 32'h0);

    store(BASE + 32'h0C, 32'hFFFF_FFFF);
    check("led_store", 32'(led), 32'h3FF);
    load("led_read", BASE + 32'h0C, 32'h3FF);
    store(BASE + 32'h18, 32'hFFFF_FFFF);
    store(BASE + 32'h20, 32'h0);
    store(BASE + 32'h2C, 32'h0);
    check("led_after_ignored", 32'(led), 32'h3FF);
    load("ctrl_unchanged", BASE + 32'h10, 32'h0);
    load("reserved_read", BASE + 32'h18, 32'h0);
    addr = BASE + 32'h20; re = 1'b1;
    #1;
    check("hit_miss", 32'(hit), 32'd0);
    tick(1);
    re = 1'b0;
    check("miss_rvalid", 32'(rvalid), 32'd0);

    addr = BASE + 32'h0C; wdata = 32'h0AA; we = 1'b1; re = 1'b1;
    exp_q.push_back(32'h3FF); nm_q.push_back("rw_same_cycle");
    tick(1);
    we = 1'b0; re = 1'b0;
    check("led_after_rw", 32'(led), 32'h0AA);
    load("led_reread", BASE + 32'h0C, 32'h0AA);

    key = 2'b10;
    repeat (6) @(posedge clock);
    #1;
    addr = BASE + 32'h08; wdata = 32'h1; we = 1'b1;
    tick(1);
    we = 1'b0;
    load("edge_set_wins", BASE + 32'h08, 32'h1);
    key = 2'b11;
    tick(12);
    store(BASE + 32'h08, 32'h1);
    load("edge_cleared_again", BASE + 32'h08, 32'h0);

    key = 2'b10;
    tick(4);
    reset = 1'b1;
    addr = BASE + 32'h00; re = 1'b1;
    tick(1);
    re = 1'b0;
    key = 2'b11;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("step_run_after_reset", 32'(step), 32'd1);
    check("led_after_reset", 32'(led), 32'd0);
    load("key_after_abort", BASE + 32'h04, 32'h0);
    load("edge_after_abort", BASE + 32'h08, 32'h0);
    load("ctrl_after_reset", BASE + 32'h10, 32'h1);

    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
